// File: rtl/data_mem_bytelane_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, fault causes, poison value.
package data_mem_bytelane_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_ALIGN = 2'b01,
        CAUSE_UNMAP = 2'b10,
        CAUSE_PERI  = 2'b11
    } cause_e;

    typedef struct packed {
        logic [31:0] addr;
        cause_e      cause;
        logic        wr;
    } fault_rec_t;

    localparam logic [31:0] POISON    = 32'hCCCC_CCCC;
    localparam int          WIN_WORDS = 1024;
    localparam int          WIN_IDX_W = 10;

endpackage

// File: rtl/data_mem_bytelane_lane_align.sv
// Combinational lane steering: lane mask and replicated store word for writes,
// lane extraction with sign/zero extension for loads.
module dm_lane_align
    import data_mem_bytelane_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  lane_mask_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s       = 8'(rword_i >> {addr_lo_i, 3'b000});
        half_s       = 16'(rword_i >> {addr_lo_i[1], 4'b0000});
        lane_mask_o  = 4'b0000;
        wword_o      = wdata_i;
        rdata_o      = POISON;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                lane_mask_o = 4'b0001 << addr_lo_i;
                wword_o     = {4{wdata_i[7:0]}};
                if (sign_ext_i) rdata_o = 32'(byte_s);
                else            rdata_o = {24'h0, byte_s};
            end
            SIZE_H: begin
                misaligned_o = addr_lo_i[0];
                lane_mask_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o      = {2{wdata_i[15:0]}};
                if (sign_ext_i) rdata_o = 32'(half_s);
                else            rdata_o = {16'h0, half_s};
            end
            SIZE_W: begin
                misaligned_o = |addr_lo_i;
                lane_mask_o  = 4'b1111;
                rdata_o      = rword_i;
            end
            default: misaligned_o = 1'b1;
        endcase
        if (misaligned_o) begin
            lane_mask_o = 4'b0000;
            rdata_o     = POISON;
        end
    end

endmodule

// File: rtl/data_mem_bytelane_peri.sv
// Small memory-mapped I/O block: switch (RO), 7-seg digits, irq enable, LEDs; word index decoded.
module dm_peripheral (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_i,
    input  logic [9:0]  idx_i,
    input  logic [11:0] wdata_i,
    input  logic [7:0]  switch_i,
    output logic [31:0] rdata_o,
    output logic        r_acc_o,
    output logic        w_acc_o,
    output logic [7:0]  led_o,
    output logic [11:0] digi_o,
    output logic        irq_o
);

    localparam logic [9:0] REG_SW   = 10'd0;
    localparam logic [9:0] REG_DIGI = 10'd1;
    localparam logic [9:0] REG_IRQ  = 10'd2;
    localparam logic [9:0] REG_LED  = 10'd3;

    logic [7:0]  led_q;
    logic [11:0] digi_q;
    logic        irq_en_q;
    logic        irq_q;

    always_comb begin
        rdata_o = 32'h0;
        r_acc_o = 1'b1;
        w_acc_o = 1'b1;
        case (idx_i)
            REG_SW:   begin rdata_o = {24'h0, switch_i}; w_acc_o = 1'b0; end
            REG_DIGI: rdata_o = {20'h0, digi_q};
            REG_IRQ:  rdata_o = {31'h0, irq_en_q};
            REG_LED:  rdata_o = {24'h0, led_q};
            default:  begin r_acc_o = 1'b0; w_acc_o = 1'b0; end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            led_q    <= 8'h0;
            digi_q   <= 12'h0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_i && w_acc_o) begin
                case (idx_i)
                    REG_DIGI: digi_q   <= wdata_i;
                    REG_IRQ:  irq_en_q <= wdata_i[0];
                    REG_LED:  led_q    <= wdata_i[7:0];
                    default:  ;
                endcase
            end
            irq_q <= irq_en_q & (|switch_i);
        end
    end

    assign led_o  = led_q;
    assign digi_o = digi_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/data_mem_bytelane.sv
// MIPS data memory: global and stack word arrays with byte lanes, peripheral window,
// and sticky capture of the first illegal access.
module data_mem_bytelane
    import data_mem_bytelane_pkg::*;
#(
    parameter logic [31:0] GLOBAL_BASE  = 32'h1001_0000,
    parameter int          GLOBAL_WORDS = 64,
    parameter logic [31:0] STACK_BASE   = 32'h7FFF_F000,
    parameter int          STACK_WORDS  = 64,
    parameter logic [31:0] PERI_BASE    = 32'h4000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        accessable_o,
    input  logic        fault_clr_i,
    output logic        fault_o,
    output logic [31:0] fault_addr_o,
    output logic [1:0]  fault_cause_o,
    output logic        fault_wr_o,
    output logic [7:0]  fault_count_o,
    input  logic [7:0]  switch_i,
    output logic [7:0]  led_o,
    output logic [11:0] digi_o,
    output logic        peri_irqout_o
);

    localparam int GA_W = (GLOBAL_WORDS > 1) ? $clog2(GLOBAL_WORDS) : 1;
    localparam int SA_W = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;
    localparam logic [WIN_IDX_W:0]   G_LIMIT = (WIN_IDX_W + 1)'(GLOBAL_WORDS);
    localparam logic [WIN_IDX_W-1:0] S_FLOOR = WIN_IDX_W'(WIN_WORDS - STACK_WORDS);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [31:0] gmem_q [GLOBAL_WORDS];
    logic [31:0] smem_q [STACK_WORDS];

    logic [WIN_IDX_W-1:0] idx;
    logic [GA_W-1:0]      g_ptr;
    logic [SA_W-1:0]      s_ptr;
    logic                 hit_g, hit_s, hit_p, g_ok, s_ok, p_ok;
    logic                 active, accessable, misaligned, store_en;
    cause_e               cause;
    logic [3:0]           lane_mask;
    logic [31:0]          wword, rword, la_rdata, p_rdata;
    logic                 p_racc, p_wacc, peri_rst_n;

    assign idx    = addr_i[11:2];
    assign g_ptr  = GA_W'(idx);
    assign s_ptr  = SA_W'(idx - S_FLOOR);
    assign hit_g  = (addr_i[31:12] == GLOBAL_BASE[31:12]);
    assign hit_s  = (addr_i[31:12] == STACK_BASE[31:12]);
    assign hit_p  = (addr_i[31:12] == PERI_BASE[31:12]);
    assign g_ok   = hit_g && ({1'b0, idx} < G_LIMIT);
    assign s_ok   = hit_s && (idx >= S_FLOOR);
    assign p_ok   = hit_p && (!rd_i || p_racc) && (!wr_i || p_wacc);
    assign active = rd_i | wr_i;
    assign rword  = hit_s ? smem_q[s_ptr] : gmem_q[g_ptr];

    dm_lane_align u_align (
        .size_i      (size_i),
        .addr_lo_i   (addr_i[1:0]),
        .sign_ext_i  (sign_ext_i),
        .wdata_i     (wdata_i),
        .rword_i     (rword),
        .lane_mask_o (lane_mask),
        .wword_o     (wword),
        .rdata_o     (la_rdata),
        .misaligned_o(misaligned)
    );

    // Cause priority: alignment, then sub-word peripheral, then unmapped/out of depth.
    always_comb begin
        cause = CAUSE_NONE;
        if (misaligned)                           cause = CAUSE_ALIGN;
        else if (hit_p && (size_i != SIZE_W))     cause = CAUSE_PERI;
        else if (!(g_ok || s_ok || p_ok))         cause = CAUSE_UNMAP;
    end

    assign accessable   = active && (cause == CAUSE_NONE);
    assign accessable_o = accessable;
    assign rdata_o      = !accessable ? POISON : (hit_p ? p_rdata : la_rdata);
    assign store_en     = wr_i && accessable && !reset_i;
    assign peri_rst_n   = ~reset_i;

    dm_peripheral u_peri (
        .clk_i   (clk_i),
        .rst_n_i (peri_rst_n),
        .wr_i    (store_en && hit_p),
        .idx_i   (idx),
        .wdata_i (wdata_i[11:0]),
        .switch_i(switch_i),
        .rdata_o (p_rdata),
        .r_acc_o (p_racc),
        .w_acc_o (p_wacc),
        .led_o   (led_o),
        .digi_o  (digi_o),
        .irq_o   (peri_irqout_o)
    );

    // Arrays carry no reset; reset only suppresses an in-flight store.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (store_en && hit_g && lane_mask[k]) gmem_q[g_ptr][8*k +: 8] <= wword[8*k +: 8];
            if (store_en && hit_s && lane_mask[k]) smem_q[s_ptr][8*k +: 8] <= wword[8*k +: 8];
        end
    end

    fault_rec_t rec_q, rec_d;
    logic       fault_q, fault_d;
    logic [7:0] count_q, count_d;

    always_comb begin
        rec_d   = rec_q;
        fault_d = fault_q;
        count_d = count_q;
        if (fault_clr_i) begin
            fault_d = 1'b0;
            count_d = 8'h0;
        end
        if (active && !accessable) begin
            if (!fault_q || fault_clr_i) begin
                rec_d   = '{addr: addr_i, cause: cause, wr: wr_i};
                fault_d = 1'b1;
            end
            count_d = fault_clr_i ? 8'd1 : sat_inc8(count_q);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rec_q   <= '{addr: 32'h0, cause: CAUSE_NONE, wr: 1'b0};
            fault_q <= 1'b0;
            count_q <= 8'h0;
        end else begin
            rec_q   <= rec_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign fault_o       = fault_q;
    assign fault_addr_o  = rec_q.addr;
    assign fault_cause_o = rec_q.cause;
    assign fault_wr_o    = rec_q.wr;
    assign fault_count_o = count_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed bench for data_mem_bytelane: lane loads/stores, fault capture and clear, reset behaviour.
module tb_data_mem_bytelane;

    logic        clk = 1'b0;
    logic        reset_i, rd_i, wr_i, sign_ext_i, fault_clr_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i, rdata_o, fault_addr_o;
    logic        accessable_o, fault_o, fault_wr_o, peri_irqout_o;
    logic [1:0]  fault_cause_o;
    logic [7:0]  fault_count_o, switch_i, led_o;
    logic [11:0] digi_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_bytelane dut (
        .clk_i(clk), .reset_i(reset_i), .rd_i(rd_i), .wr_i(wr_i), .size_i(size_i),
        .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .accessable_o(accessable_o), .fault_clr_i(fault_clr_i), .fault_o(fault_o),
        .fault_addr_o(fault_addr_o), .fault_cause_o(fault_cause_o), .fault_wr_o(fault_wr_o),
        .fault_count_o(fault_count_o), .switch_i(switch_i), .led_o(led_o), .digi_o(digi_o),
        .peri_irqout_o(peri_irqout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
        rd_i = r; wr_i = w; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = d;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_i = 1'b0; wr_i = 1'b0;
        #1;
    endtask

    task automatic clear_fault();
        idle();
        fault_clr_i = 1'b1;
        step();
        fault_clr_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; rd_i = 1'b0; wr_i = 1'b0; size_i = 2'b10; sign_ext_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; fault_clr_i = 1'b0; switch_i = 8'h3C;
        #2;
        chk("rst_fault", fault_o, 1'b0);
        chk("rst_addr", fault_addr_o, 32'h0);
        chk("rst_cause", fault_cause_o, 2'b00);
        chk("rst_wr", fault_wr_o, 1'b0);
        chk("rst_count", fault_count_o, 8'h0);
        chk("idle_acc", accessable_o, 1'b0);
        chk("idle_rdata", rdata_o, 32'hCCCC_CCCC);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;

        // word store then byte/half loads
        acc(0, 1, 2'b10, 0, 32'h1001_0000, 32'h1122_3344);
        chk("sw_acc", accessable_o, 1'b1);
        step();
        acc(1, 0, 2'b00, 1, 32'h1001_0003, 32'h0);
        chk("lb3", rdata_o, 32'h0000_0011);
        acc(1, 0, 2'b00, 0, 32'h1001_0003, 32'h0);
        chk("lbu3", rdata_o, 32'h0000_0011);
        acc(1, 0, 2'b01, 1, 32'h1001_0002, 32'h0);
        chk("lh2", rdata_o, 32'h0000_1122);
        acc(1, 0, 2'b01, 1, 32'h1001_0000, 32'h0);
        chk("lh0", rdata_o, 32'h0000_3344);

        // byte and half stores into one word
        acc(0, 1, 2'b00, 0, 32'h1001_0001, 32'h0000_00F0);
        step();
        acc(1, 0, 2'b10, 0, 32'h1001_0000, 32'h0);
        chk("lw_after_sb", rdata_o, 32'h1122_F044);
        acc(1, 0, 2'b00, 1, 32'h1001_0001, 32'h0);
        chk("lb1_sx", rdata_o, 32'hFFFF_FFF0);
        acc(1, 0, 2'b00, 0, 32'h1001_0001, 32'h0);
        chk("lbu1", rdata_o, 32'h0000_00F0);
        acc(0, 1, 2'b01, 0, 32'h1001_0002, 32'h0000_ABCD);
        step();
        acc(1, 0, 2'b10, 0, 32'h1001_0000, 32'h0);
        chk("lw_after_sh", rdata_o, 32'hABCD_F044);
        acc(1, 0, 2'b01, 1, 32'h1001_0002, 32'h0);
        chk("lh2_sx", rdata_o, 32'hFFFF_ABCD);
        acc(1, 1, 2'b10, 0, 32'h1001_0000, 32'h5566_7788);
        chk("rdwr_pre", rdata_o, 32'hABCD_F044);
        step();
        acc(1, 0, 2'b10, 0, 32'h1001_0000, 32'h0);
        chk("rdwr_post", rdata_o, 32'h5566_7788);
        acc(0, 1, 2'b10, 0, 32'h1001_0000, 32'hABCD_F044);
        step();

        // misaligned word load
        acc(1, 0, 2'b10, 0, 32'h1001_0002, 32'h0);
        chk("mis_acc", accessable_o, 1'b0);
        chk("mis_rdata", rdata_o, 32'hCCCC_CCCC);
        step();
        idle();
        chk("mis_fault", fault_o, 1'b1);
        chk("mis_cause", fault_cause_o, 2'b01);
        chk("mis_addr", fault_addr_o, 32'h1001_0002);
        chk("mis_wr", fault_wr_o, 1'b0);
        chk("mis_count", fault_count_o, 8'd1);
        clear_fault();
        chk("clr_fault", fault_o, 1'b0);
        chk("clr_count", fault_count_o, 8'd0);
        chk("clr_addr_hold", fault_addr_o, 32'h1001_0002);
        acc(1, 0, 2'b11, 0, 32'h1001_0000, 32'h0);
        chk("size11_acc", accessable_o, 1'b0);
        step();
        idle();
        chk("size11_cause", fault_cause_o, 2'b01);
        clear_fault();

        // stack window
        acc(0, 1, 2'b10, 0, 32'h7FFF_FF00, 32'hCAFE_F00D);
        step();
        acc(0, 1, 2'b10, 0, 32'h7FFF_FFFC, 32'hDEAD_BEEF);
        step();
        acc(1, 0, 2'b10, 0, 32'h7FFF_FFFC, 32'h0);
        chk("stack_lw", rdata_o, 32'hDEAD_BEEF);
        acc(0, 1, 2'b10, 0, 32'h7FFF_F000, 32'h1234_5678);
        chk("stack_low_acc", accessable_o, 1'b0);
        step();
        idle();
        chk("stack_low_fault", fault_o, 1'b1);
        chk("stack_low_cause", fault_cause_o, 2'b10);
        chk("stack_low_wr", fault_wr_o, 1'b1);
        chk("stack_low_addr", fault_addr_o, 32'h7FFF_F000);
        acc(1, 0, 2'b10, 0, 32'h7FFF_FF00, 32'h0);
        chk("stack_unchanged", rdata_o, 32'hCAFE_F00D);
        acc(0, 1, 2'b10, 0, 32'h1001_0100, 32'h9999_9999);
        step();
        acc(1, 0, 2'b10, 0, 32'h1001_0000, 32'h0);
        chk("global_unchanged", rdata_o, 32'hABCD_F044);
        chk("depth_count", fault_count_o, 8'd2);
        clear_fault();

        // peripheral window
        acc(0, 1, 2'b10, 0, 32'h4000_000C, 32'h0000_00A5);
        step();
        chk("led_set", led_o, 8'hA5);
        acc(1, 0, 2'b10, 0, 32'h4000_000C, 32'h0);
        chk("led_read", rdata_o, 32'h0000_00A5);
        acc(1, 0, 2'b10, 0, 32'h4000_0000, 32'h0);
        chk("switch_read", rdata_o, 32'h0000_003C);
        acc(0, 1, 2'b00, 0, 32'h4000_000C, 32'h0000_00FF);
        chk("peri_sb_acc", accessable_o, 1'b0);
        step();
        idle();
        chk("peri_led_hold", led_o, 8'hA5);
        chk("peri_cause", fault_cause_o, 2'b11);
        chk("peri_addr", fault_addr_o, 32'h4000_000C);
        chk("peri_count", fault_count_o, 8'd1);
        acc(1, 0, 2'b10, 0, 32'h2000_0000, 32'h0);
        step();
        idle();
        chk("second_addr", fault_addr_o, 32'h4000_000C);
        chk("second_cause", fault_cause_o, 2'b11);
        chk("second_count", fault_count_o, 8'd2);
        fault_clr_i = 1'b1;
        acc(1, 0, 2'b10, 0, 32'h1001_0001, 32'h0);
        step();
        fault_clr_i = 1'b0;
        idle();
        chk("clrnew_fault", fault_o, 1'b1);
        chk("clrnew_count", fault_count_o, 8'd1);
        chk("clrnew_addr", fault_addr_o, 32'h1001_0001);
        chk("clrnew_cause", fault_cause_o, 2'b01);

        // reset during a legal store
        reset_i = 1'b1;
        acc(0, 1, 2'b10, 0, 32'h1001_0000, 32'h5555_5555);
        chk("rst2_fault", fault_o, 1'b0);
        chk("rst2_count", fault_count_o, 8'd0);
        chk("rst2_addr", fault_addr_o, 32'h0);
        chk("rst2_cause", fault_cause_o, 2'b00);
        chk("rst2_led", led_o, 8'h00);
        step();
        reset_i = 1'b0;
        idle();
        acc(1, 0, 2'b10, 0, 32'h1001_0000, 32'h0);
        chk("rst_store_dropped", rdata_o, 32'hABCD_F044);

        // saturating fault counter
        acc(1, 0, 2'b10, 0, 32'h2000_0000, 32'h0);
        repeat (255) @(posedge clk);
        #1;
        chk("count_255", fault_count_o, 8'd255);
        repeat (45) @(posedge clk);
        #1;
        idle();
        chk("count_sat", fault_count_o, 8'd255);
        chk("sat_fault", fault_o, 1'b1);
        chk("sat_addr", fault_addr_o, 32'h2000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
